// File: rtl/cmd_pkt_pkg.sv
// rtl/cmd_pkt_pkg.sv - shared constants and enums for the command packet deframer
package cmd_pkt_pkg;

  localparam logic [7:0] CMD_SYNC      = 8'hA5;
  localparam logic [7:0] CMD_TYPE_PROG = 8'h01;
  localparam logic [7:0] CMD_TYPE_RUN  = 8'h02;

  typedef enum logic [1:0] {
    ERR_NONE = 2'd0,
    ERR_TYPE = 2'd1,
    ERR_LEN  = 2'd2,
    ERR_CHK  = 2'd3
  } err_code_t;

  typedef enum logic [2:0] {
    IDLE,
    TYPE,
    LEN,
    PAYLOAD,
    CHECK
  } deframe_state_t;

endpackage

// File: rtl/byte_gap_timer.sv
// rtl/byte_gap_timer.sv - counts idle cycles between bytes; pulses expired at the limit
module byte_gap_timer #(
  parameter int TIMEOUT_CYCLES = 20000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  input  logic strobe,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);

  logic [CW-1:0] count;

  // A byte arriving on the limit cycle suppresses expiry and restarts the count.
  assign expired = enable && !clear && !strobe && (count == LIMIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear || strobe || !enable || (count == LIMIT)) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/cmd_packet_deframer.sv
// rtl/cmd_packet_deframer.sv - turns UART bytes into checksum-verified command packets
module cmd_packet_deframer
  import cmd_pkt_pkg::*;
#(
  parameter int MAX_PAYLD_PKT_BITS = 64,
  parameter int TIMEOUT_CYCLES     = 20000
) (
  input  logic                          i_clk,
  input  logic                          n_btn_reset,
  input  logic                          rx_valid,
  input  logic [7:0]                    rx_data,
  output logic                          valid_input,
  output logic                          is_prog_mode,
  output logic [MAX_PAYLD_PKT_BITS-1:0] payload_data,
  output logic                          pkt_err,
  output logic [1:0]                    err_code,
  output logic                          err_timeout
);

  localparam int MAXB = MAX_PAYLD_PKT_BITS / 8;
  localparam int LW   = $clog2(MAXB + 1);

  deframe_state_t state, next_state;

  logic [MAX_PAYLD_PKT_BITS-1:0] shadow, masked;
  logic [LW-1:0] idx, idx_next, len;
  logic [7:0]    chk;
  logic          type_prog;
  logic          expired;
  logic          accept, drop, drop_timeout;
  err_code_t     drop_code;
  logic          len_ok;

  byte_gap_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_gap_timer (
    .clk     (i_clk),
    .rst_n   (n_btn_reset),
    .clear   (state == IDLE),
    .enable  (state != IDLE),
    .strobe  (rx_valid),
    .expired (expired)
  );

  assign idx_next = idx + 1'b1;
  assign len_ok   = (rx_data != 8'h00) && (int'(rx_data) <= MAXB);

  always_comb begin
    masked = '0;
    for (int i = 0; i < MAXB; i++) begin
      if (LW'(i) < len) masked[8*i +: 8] = shadow[8*i +: 8];
    end
  end

  always_ff @(posedge i_clk or negedge n_btn_reset) begin
    if (!n_btn_reset) state <= IDLE;
    else              state <= next_state;
  end

  always_comb begin
    next_state   = state;
    accept       = 1'b0;
    drop         = 1'b0;
    drop_code    = ERR_NONE;
    drop_timeout = 1'b0;
    if (rx_valid) begin
      case (state)
        IDLE: if (rx_data == CMD_SYNC) next_state = TYPE;
        TYPE: begin
          if (rx_data == CMD_TYPE_PROG || rx_data == CMD_TYPE_RUN) begin
            next_state = LEN;
          end else begin
            next_state = IDLE;
            drop       = 1'b1;
            drop_code  = ERR_TYPE;
          end
        end
        LEN: begin
          if (len_ok) begin
            next_state = PAYLOAD;
          end else begin
            next_state = IDLE;
            drop       = 1'b1;
            drop_code  = ERR_LEN;
          end
        end
        PAYLOAD: if (idx_next == len) next_state = CHECK;
        CHECK: begin
          next_state = IDLE;
          if (rx_data == chk) begin
            accept = 1'b1;
          end else begin
            drop      = 1'b1;
            drop_code = ERR_CHK;
          end
        end
        default: next_state = IDLE;
      endcase
    end else if (expired) begin
      next_state   = IDLE;
      drop         = 1'b1;
      drop_code    = ERR_CHK;
      drop_timeout = 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge n_btn_reset) begin
    if (!n_btn_reset) begin
      valid_input  <= 1'b0;
      pkt_err      <= 1'b0;
      is_prog_mode <= 1'b0;
      payload_data <= '0;
      err_code     <= ERR_NONE;
      err_timeout  <= 1'b0;
      shadow       <= '0;
      idx          <= '0;
      len          <= '0;
      chk          <= 8'h00;
      type_prog    <= 1'b0;
    end else begin
      valid_input <= accept;
      pkt_err     <= drop;
      if (accept) begin
        payload_data <= masked;
        is_prog_mode <= type_prog;
        err_code     <= ERR_NONE;
        err_timeout  <= 1'b0;
      end
      if (drop) begin
        err_code <= drop_code;
        if (drop_timeout) err_timeout <= 1'b1;
      end
      if (rx_valid) begin
        case (state)
          IDLE: begin
            if (rx_data == CMD_SYNC) begin
              shadow <= '0;
              idx    <= '0;
              chk    <= 8'h00;
            end
          end
          TYPE: begin
            type_prog <= (rx_data == CMD_TYPE_PROG);
            chk       <= rx_data;
          end
          LEN: begin
            len <= LW'(rx_data);
            idx <= '0;
            chk <= chk ^ rx_data;
          end
          PAYLOAD: begin
            for (int i = 0; i < MAXB; i++) begin
              if (idx == LW'(i)) shadow[8*i +: 8] <= rx_data;
            end
            chk <= chk ^ rx_data;
            idx <= idx_next;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cmd_packet_deframer.sv
// tb/tb_cmd_packet_deframer.sv - scoreboard bench for cmd_packet_deframer
module tb_cmd_packet_deframer;

  localparam int TMO = 40;

  typedef logic [7:0] bq_t[$];
  typedef struct {
    logic        acc;
    logic        prog;
    logic [63:0] payload;
    logic [1:0]  code;
    logic        tmo;
  } exp_t;

  logic        i_clk = 1'b0;
  logic        n_btn_reset = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        valid_input, is_prog_mode, pkt_err, err_timeout;
  logic [63:0] payload_data;
  logic [1:0]  err_code;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail = 0;

  logic        m_prog = 1'b0;
  logic [63:0] m_payload = '0;
  logic        m_tmo = 1'b0;
  logic [1:0]  m_code = 2'd0;

  bq_t seq;

  cmd_packet_deframer #(.MAX_PAYLD_PKT_BITS(64), .TIMEOUT_CYCLES(TMO)) dut (
    .i_clk        (i_clk),
    .n_btn_reset  (n_btn_reset),
    .rx_valid     (rx_valid),
    .rx_data      (rx_data),
    .valid_input  (valid_input),
    .is_prog_mode (is_prog_mode),
    .payload_data (payload_data),
    .pkt_err      (pkt_err),
    .err_code     (err_code),
    .err_timeout  (err_timeout)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic push_accept(input logic prog, input logic [63:0] payload);
    exp_t e;
    m_prog = prog; m_payload = payload; m_tmo = 1'b0; m_code = 2'd0;
    e = '{acc: 1'b1, prog: prog, payload: payload, code: 2'd0, tmo: 1'b0};
    exp_q.push_back(e);
  endtask

  task automatic push_drop(input logic [1:0] code, input logic tmo);
    exp_t e;
    m_code = code;
    if (tmo) m_tmo = 1'b1;
    e = '{acc: 1'b0, prog: m_prog, payload: m_payload, code: code, tmo: m_tmo};
    exp_q.push_back(e);
  endtask

  task automatic send(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge i_clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_seq(input bq_t bytes);
    foreach (bytes[i]) send(bytes[i]);
  endtask

  task automatic send_gapped(input bq_t bytes, input int gap);
    foreach (bytes[i]) begin
      send(bytes[i]);
      if (i != bytes.size() - 1) repeat (gap) @(negedge i_clk);
    end
  endtask

  always @(negedge i_clk) begin
    if (n_btn_reset && (valid_input || pkt_err)) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", {62'd0, valid_input, pkt_err}, 64'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("pulse_kind", {62'd0, valid_input, pkt_err}, e.acc ? 64'd2 : 64'd1);
        check("payload_data", payload_data, e.payload);
        check("is_prog_mode", {63'd0, is_prog_mode}, {63'd0, e.prog});
        check("err_code", {62'd0, err_code}, {62'd0, e.code});
        check("err_timeout", {63'd0, err_timeout}, {63'd0, e.tmo});
      end
    end
  end

  initial begin
    #1;
    check("reset_outputs", {valid_input, is_prog_mode, pkt_err, err_code, err_timeout, 58'd0} | payload_data, 64'd0);
    repeat (2) @(negedge i_clk);
    n_btn_reset = 1'b1;
    @(negedge i_clk);

    push_accept(1'b1, 64'h3C05);
    seq = '{8'hA5, 8'h01, 8'h02, 8'h05, 8'h3C, 8'h3A}; send_seq(seq);

    push_drop(2'd3, 1'b0);
    seq = '{8'hA5, 8'h01, 8'h02, 8'h05, 8'h3C, 8'h3B}; send_seq(seq);

    push_drop(2'd2, 1'b0);
    seq = '{8'hA5, 8'h01, 8'h09}; send_seq(seq);
    push_accept(1'b0, 64'h33_2211);
    seq = '{8'hA5, 8'h02, 8'h03, 8'h11, 8'h22, 8'h33, 8'h01}; send_seq(seq);

    push_accept(1'b0, 64'h07);
    seq = '{8'h00, 8'hFF, 8'h12, 8'hA5, 8'h02, 8'h01, 8'h07, 8'h04}; send_seq(seq);

    push_drop(2'd1, 1'b0);
    seq = '{8'hA5, 8'h07}; send_seq(seq);

    push_drop(2'd2, 1'b0);
    seq = '{8'hA5, 8'h01, 8'h00}; send_seq(seq);

    push_accept(1'b1, 64'h0807_0605_0403_0201);
    seq = '{8'hA5, 8'h01, 8'h08, 8'h01, 8'h02, 8'h03, 8'h04,
            8'h05, 8'h06, 8'h07, 8'h08, 8'h01}; send_seq(seq);

    push_accept(1'b0, 64'hA5);
    seq = '{8'hA5, 8'h02, 8'h01, 8'hA5, 8'hA6}; send_seq(seq);

    push_drop(2'd3, 1'b1);
    seq = '{8'hA5, 8'h01, 8'h02, 8'h05}; send_seq(seq);
    repeat (TMO + 5) @(negedge i_clk);
    check("timeout_sticky", {63'd0, err_timeout}, 64'd1);

    push_accept(1'b0, 64'h09);
    seq = '{8'hA5, 8'h02, 8'h01, 8'h09, 8'h0A}; send_gapped(seq, TMO);
    repeat (3) @(negedge i_clk);
    check("timeout_cleared", {63'd0, err_timeout}, 64'd0);

    seq = '{8'hA5, 8'h01, 8'h02}; send_seq(seq);
    n_btn_reset = 1'b0;
    #1;
    check("midpkt_reset_outputs", {valid_input, is_prog_mode, pkt_err, err_code, err_timeout, 58'd0} | payload_data, 64'd0);
    m_prog = 1'b0; m_payload = '0; m_tmo = 1'b0; m_code = 2'd0;
    repeat (2) @(negedge i_clk);
    n_btn_reset = 1'b1;
    @(negedge i_clk);
    push_accept(1'b1, 64'h3C05);
    seq = '{8'hA5, 8'h01, 8'h02, 8'h05, 8'h3C, 8'h3A}; send_seq(seq);

    repeat (10) @(negedge i_clk);
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
